// File: rtl/data_recovery_block.sv
// data_recovery_block: undoes a per-word 8-bit transform and delivers the result through
// a two-entry (output + skid) valid/ready buffer with transfer and error counters.
module data_recovery_block #(
   parameter int CNT_W = 16,
   parameter int ERR_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             valid_in,
   output logic             ready_in,
   input  logic [7:0]       data_in,
   input  logic [1:0]       mode,
   output logic             valid_out,
   input  logic             ready_out,
   output logic [7:0]       data_out,
   output logic             err_out,
   output logic [CNT_W-1:0] word_count,
   output logic [ERR_W-1:0] err_count
);
   typedef struct packed {
      logic [7:0] data;
      logic       err;
      logic       valid;
   } slot_t;
   slot_t out_q, out_d, skid_q, skid_d;
   logic rdy_q;
   logic acc, xfer;
   logic [7:0] rec;
   logic rec_err;
   logic [CNT_W-1:0] wc_q;
   logic [ERR_W-1:0] ec_q;
   assign ready_in   = rdy_q;
   assign valid_out  = out_q.valid;
   assign data_out   = out_q.data;
   assign err_out    = out_q.err;
   assign word_count = wc_q;
   assign err_count  = ec_q;
   assign acc  = valid_in & rdy_q & ~rst;
   assign xfer = out_q.valid & ready_out;
   always_comb begin
      rec = mode == 2'b01 ? data_in - 8'd1 :
            mode == 2'b10 ? ~data_in :
            mode == 2'b11 ? {1'b0, data_in[7:1]} : data_in;
      rec_err = (&mode) & data_in[0];
   end
   // ready_in is ~skid_valid, so an accept never coincides with a full skid slot.
   always_comb begin
      out_d  = out_q;
      skid_d = skid_q;
      if (!out_q.valid || xfer) begin
         if (skid_q.valid) begin
            out_d        = skid_q;
            skid_d.valid = 1'b0;
         end else if (acc) begin
            out_d = {rec, rec_err, 1'b1};
         end else begin
            out_d.valid = 1'b0;
         end
      end else if (acc) begin
         skid_d = {rec, rec_err, 1'b1};
      end
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         out_q  <= '0;
         skid_q <= '0;
         rdy_q  <= 1'b1;
         wc_q   <= '0;
         ec_q   <= '0;
      end else begin
         out_q  <= out_d;
         skid_q <= skid_d;
         rdy_q  <= ~skid_d.valid;
         if (xfer) wc_q <= wc_q + CNT_W'(1);
         if (xfer && out_q.err && !(&ec_q)) ec_q <= ec_q + ERR_W'(1);
      end
   end
endmodule
